alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Round-robin scheduler that shares the single 5-bit ALU (S[1:0] select, X/Y operands, F/Cout/Overflow results) between two requesters, A and B. It arbitrates, latches the winner's opcode and operands onto the ALU inputs, and holds them stable for a programmable settle time. It then captures F/Cout/Overflow and returns them to the winner over a valid/ready response handshake. It sits between the requesters and the combinational ALU; the ALU itself is instantiated outside this block.

## Interface
- SETTLE, 1: cycles the ALU inputs are held before results are captured; legal range 1..15
- CNT_W, 8: width of the completed-operation counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- a_req_valid  in  1  requester A has an operation pending
- a_req_ready  out  1  A's request accepted this cycle
- a_req_s  in  2  A's opcode (ALU S)
- a_req_x, a_req_y  in  5 each  A's operands
- a_rsp_valid  out  1  result on rsp_* belongs to A
- a_rsp_ready  in  1  A accepts the result
- b_req_valid, b_req_ready, b_req_s, b_req_x, b_req_y, b_rsp_valid, b_rsp_ready: same as the A ports, for requester B
- rsp_f  out  5  captured ALU F
- rsp_cout  out  1  captured ALU Cout
- rsp_ovf  out  1  captured ALU Overflow
- alu_s  out  2  registered opcode to the ALU
- alu_x, alu_y  out  5 each  registered operands to the ALU
- alu_f  in  5, alu_cout  in  1, alu_ovf  in  1: ALU results
- busy  out  1  high in any state other than IDLE
- op_count  out  CNT_W  number of completed response handshakes; wraps

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: grant logic is combinational.
  - If only one requester's valid is high, grant it.
  - If both are high, grant the requester that was not granted last. The `last` pointer resets to B, so A wins the first tie.
  - Assert the granted requester's req_ready in the same cycle.
  - At the edge: load alu_s/alu_x/alu_y from the winner, record the owner, update `last`, load settle counter with SETTLE-1, and go to ISSUE.
- ISSUE: alu_* hold stable and both req_ready signals are low.
  - Each edge with counter≠0 decrements the counter.
  - The edge with counter==0 captures alu_f/alu_cout/alu_ovf into rsp_* and goes to RESP.
- RESP: assert the owner's rsp_valid; rsp_* are held.
  - On an edge with the owner's rsp_ready high: clear rsp_valid, increment op_count (mod 2^CNT_W), go to IDLE.
  - The non-owner's rsp_ready is ignored.
- Requests are never accepted outside IDLE; a requester must hold valid and its fields until ready.
- The block does not interpret opcodes. The arithmetic is entirely the ALU's, and the 5-bit results are passed through unmodified.
- Reset values: all req_ready/rsp_valid = 0; rsp_f, rsp_cout, rsp_ovf, alu_s, alu_x, alu_y = 0; busy = 0; op_count = 0; state IDLE; last = B.
- Reset mid-operation abandons the operation: no response is issued and op_count is unchanged.

## Timing
- Request accepted at edge E0.
- alu_* are valid in the cycle after E0; ISSUE lasts exactly SETTLE cycles.
- rsp_valid goes high after edge E0+SETTLE.
- With rsp_ready already high: response handshake at E0+SETTLE+1, IDLE in the following cycle, next accept at the earliest at E0+SETTLE+2.
- Back-to-back throughput is one operation per SETTLE+2 cycles.
- rsp_valid is never asserted for both requesters at once.
- alu_* change only on an IDLE accept edge or on reset.
- rsp_* change only on a capture edge or on reset.
- Simultaneous valid in IDLE: exactly one ready.
  - A requester losing a tie wins the next arbitration if it is still valid.
  - A continuously requesting pair therefore alternates A, B, A, B.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.

## Test plan
- Reset behaviour: hold rst for 3 cycles with both valids high -> all outputs 0, no ready; after release, A is granted first.
- Single request, SETTLE=1, ALU bench stub F=X^Y, Cout=X[4], Ovf=Y[0]: A sends S=00, X=01111, Y=00001 at E0 -> alu_x=01111 and alu_y=00001 after E0; a_rsp_valid after E0+1 with rsp_f=01110, cout=0, ovf=1; op_count=1 after the handshake.
- Contention and fairness: both valid continuously, 6 operations, rsp_ready tied high -> grant order A,B,A,B,A,B; spacing exactly SETTLE+2 cycles; b_rsp_valid never high together with a_rsp_valid.
- Response backpressure: SETTLE=3, B's op X=10100, Y=10110, b_rsp_ready low for 5 cycles -> rsp_* stable, no new accept while A is valid, a_rsp_ready toggling is ignored; after ready, IDLE follows, then A is granted.
- Reset mid-operation: assert rst during ISSUE and again in a separate run during RESP -> no rsp_valid, op_count unchanged, state IDLE, last = B.
- Counter wrap: CNT_W=2, five completed operations -> op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_share_ctrl_if.sv
// Bundle of the two requester handshakes, the shared response bus and the ALU hookup.
// The slave side is the scheduler; the master side is the requesters plus the ALU.
interface alu_share_ctrl_if;
    logic       a_req_valid;
    logic       a_req_ready;
    logic [1:0] a_req_s;
    logic [4:0] a_req_x;
    logic [4:0] a_req_y;
    logic       a_rsp_valid;
    logic       a_rsp_ready;

    logic       b_req_valid;
    logic       b_req_ready;
    logic [1:0] b_req_s;
    logic [4:0] b_req_x;
    logic [4:0] b_req_y;
    logic       b_rsp_valid;
    logic       b_rsp_ready;

    logic [4:0] rsp_f;
    logic       rsp_cout;
    logic       rsp_ovf;

    logic [1:0] alu_s;
    logic [4:0] alu_x;
    logic [4:0] alu_y;
    logic [4:0] alu_f;
    logic       alu_cout;
    logic       alu_ovf;

    modport master (
        output a_req_valid, a_req_s, a_req_x, a_req_y, a_rsp_ready,
        output b_req_valid, b_req_s, b_req_x, b_req_y, b_rsp_ready,
        output alu_f, alu_cout, alu_ovf,
        input  a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid,
        input  rsp_f, rsp_cout, rsp_ovf, alu_s, alu_x, alu_y
    );

    modport slave (
        input  a_req_valid, a_req_s, a_req_x, a_req_y, a_rsp_ready,
        input  b_req_valid, b_req_s, b_req_x, b_req_y, b_rsp_ready,
        input  alu_f, alu_cout, alu_ovf,
        output a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid,
        output rsp_f, rsp_cout, rsp_ovf, alu_s, alu_x, alu_y
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler sharing one external combinational ALU between requesters A and B:
// latch the winner's operation, hold it SETTLE cycles, capture the result and hand it back.
module alu_share_ctrl #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_share_ctrl_if.slave  bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;

    localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;     // 1: B was granted last
    logic             owner_q, owner_d;   // 1: B owns the operation in flight
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       alu_s_q, alu_s_d;
    logic [4:0]       alu_x_q, alu_x_d;
    logic [4:0]       alu_y_q, alu_y_d;
    logic [4:0]       rsp_f_q, rsp_f_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic grant_a, grant_b;
    logic owner_rsp_ready;

    // Ready is withheld while reset is asserted so no request is dropped into a reset edge.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (bus.a_req_valid && bus.b_req_valid) begin
                grant_a = last_q;
                grant_b = !last_q;
            end else begin
                grant_a = bus.a_req_valid;
                grant_b = bus.b_req_valid;
            end
        end
    end

    assign owner_rsp_ready = owner_q ? bus.b_rsp_ready : bus.a_rsp_ready;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        alu_s_d    = alu_s_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        rsp_f_d    = rsp_f_q;
        rsp_cout_d = rsp_cout_q;
        rsp_ovf_d  = rsp_ovf_q;
        op_count_d = op_count_q;
        case (state_q)
            StIdle: begin
                if (grant_a || grant_b) begin
                    state_d = StIssue;
                    owner_d = grant_b;
                    last_d  = grant_b;
                    cnt_d   = SettleLoad;
                    alu_s_d = grant_b ? bus.b_req_s : bus.a_req_s;
                    alu_x_d = grant_b ? bus.b_req_x : bus.a_req_x;
                    alu_y_d = grant_b ? bus.b_req_y : bus.a_req_y;
                end
            end
            StIssue: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    rsp_f_d    = bus.alu_f;
                    rsp_cout_d = bus.alu_cout;
                    rsp_ovf_d  = bus.alu_ovf;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (owner_rsp_ready) begin
                    state_d    = StIdle;
                    op_count_d = op_count_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            cnt_q      <= 4'd0;
            alu_s_q    <= 2'd0;
            alu_x_q    <= 5'd0;
            alu_y_q    <= 5'd0;
            rsp_f_q    <= 5'd0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            alu_s_q    <= alu_s_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            rsp_f_q    <= rsp_f_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_ovf_q  <= rsp_ovf_d;
            op_count_q <= op_count_d;
        end
    end

    assign bus.a_req_ready = grant_a;
    assign bus.b_req_ready = grant_b;
    assign bus.a_rsp_valid = (state_q == StResp) && !owner_q;
    assign bus.b_rsp_valid = (state_q == StResp) && owner_q;
    assign bus.rsp_f       = rsp_f_q;
    assign bus.rsp_cout    = rsp_cout_q;
    assign bus.rsp_ovf     = rsp_ovf_q;
    assign bus.alu_s       = alu_s_q;
    assign bus.alu_x       = alu_x_q;
    assign bus.alu_y       = alu_y_q;
    assign busy            = (state_q != StIdle);
    assign op_count        = op_count_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: instance 0 has SETTLE=1/CNT_W=8, instance 1 SETTLE=3/CNT_W=2,
// both checked every cycle against a timestamp-based transaction model.
module tb_alu_share_ctrl;

    localparam int MDir  = 0;
    localparam int MCont = 1;
    localparam int MRand = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rv [2][2];
    logic       rr [2][2];
    logic [1:0] rs [2][2];
    logic [4:0] rx [2][2];
    logic [4:0] ry [2][2];

    wire       o_rdy [2][2];
    wire       o_rv  [2][2];
    wire [1:0] o_s   [2];
    wire [4:0] o_x   [2];
    wire [4:0] o_y   [2];
    wire [4:0] o_f   [2];
    wire       o_co  [2];
    wire       o_ov  [2];
    wire       o_busy [2];
    wire [7:0] o_cnt [2];

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int unsigned S  = (g == 0) ? 1 : 3;
        localparam int unsigned CW = (g == 0) ? 8 : 2;
        logic [CW-1:0] cnt;
        logic          busy;
        alu_share_ctrl_if bus ();

        alu_share_ctrl #(.SETTLE(S), .CNT_W(CW)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .busy     (busy),
            .op_count (cnt)
        );

        assign bus.a_req_valid = rv[g][0];
        assign bus.a_req_s     = rs[g][0];
        assign bus.a_req_x     = rx[g][0];
        assign bus.a_req_y     = ry[g][0];
        assign bus.a_rsp_ready = rr[g][0];
        assign bus.b_req_valid = rv[g][1];
        assign bus.b_req_s     = rs[g][1];
        assign bus.b_req_x     = rx[g][1];
        assign bus.b_req_y     = ry[g][1];
        assign bus.b_rsp_ready = rr[g][1];
        // ALU stub: F = X ^ Y, Cout = X[4], Ovf = Y[0]
        assign bus.alu_f       = bus.alu_x ^ bus.alu_y;
        assign bus.alu_cout    = bus.alu_x[4];
        assign bus.alu_ovf     = bus.alu_y[0];

        assign o_rdy[g][0] = bus.a_req_ready;
        assign o_rdy[g][1] = bus.b_req_ready;
        assign o_rv[g][0]  = bus.a_rsp_valid;
        assign o_rv[g][1]  = bus.b_rsp_valid;
        assign o_s[g]      = bus.alu_s;
        assign o_x[g]      = bus.alu_x;
        assign o_y[g]      = bus.alu_y;
        assign o_f[g]      = bus.rsp_f;
        assign o_co[g]     = bus.rsp_cout;
        assign o_ov[g]     = bus.rsp_ovf;
        assign o_busy[g]   = busy;
        assign o_cnt[g]    = 8'(cnt);
    end

    // Transaction model: an operation accepted at the end of cycle n0 is in flight until the
    // handshake; its response is visible from cycle n0+SETTLE+1.
    bit m_act [2];
    bit m_own [2];
    bit m_last [2];
    int m_n0 [2];
    int m_cnt [2];
    int m_s [2], m_x [2], m_y [2], m_f [2], m_co [2], m_ov [2];
    bit acc [2][2];

    int n, nvec, nerr, mode;
    bit chk_en;
    int g_own [2][8];
    int g_cyc [2][8];
    int g_num [2];
    bit rec_cnt;
    int prev1;
    int cs [8];
    int cs_n;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_cycle(input int k);
        int  s, g;
        bit  resp;
        s = (k == 0) ? 1 : 3;
        g = -1;
        if (!m_act[k] && !rst) begin
            if (rv[k][0] && rv[k][1]) g = m_last[k] ? 0 : 1;
            else if (rv[k][0]) g = 0;
            else if (rv[k][1]) g = 1;
        end
        resp = m_act[k] && (n > m_n0[k] + s);
        if (chk_en) begin
            check_eq($sformatf("k%0d a_req_ready", k), o_rdy[k][0], g == 0);
            check_eq($sformatf("k%0d b_req_ready", k), o_rdy[k][1], g == 1);
            check_eq($sformatf("k%0d a_rsp_valid", k), o_rv[k][0], resp && !m_own[k]);
            check_eq($sformatf("k%0d b_rsp_valid", k), o_rv[k][1], resp && m_own[k]);
            check_eq($sformatf("k%0d busy", k), o_busy[k], m_act[k]);
            check_eq($sformatf("k%0d alu_s", k), o_s[k], m_s[k]);
            check_eq($sformatf("k%0d alu_x", k), o_x[k], m_x[k]);
            check_eq($sformatf("k%0d alu_y", k), o_y[k], m_y[k]);
            check_eq($sformatf("k%0d rsp_f", k), o_f[k], m_f[k]);
            check_eq($sformatf("k%0d rsp_cout", k), o_co[k], m_co[k]);
            check_eq($sformatf("k%0d rsp_ovf", k), o_ov[k], m_ov[k]);
            check_eq($sformatf("k%0d op_count", k), o_cnt[k], m_cnt[k]);
        end
        acc[k][0] = 1'b0;
        acc[k][1] = 1'b0;
        if (rst) begin
            m_act[k] = 0; m_last[k] = 1; m_cnt[k] = 0;
            m_s[k] = 0; m_x[k] = 0; m_y[k] = 0; m_f[k] = 0; m_co[k] = 0; m_ov[k] = 0;
        end else if (g >= 0) begin
            m_act[k]  = 1;
            m_own[k]  = (g == 1);
            m_last[k] = (g == 1);
            m_n0[k]   = n;
            m_s[k]    = rs[k][g];
            m_x[k]    = rx[k][g];
            m_y[k]    = ry[k][g];
            acc[k][g] = 1'b1;
            if (g_num[k] < 8) begin
                g_own[k][g_num[k]] = g;
                g_cyc[k][g_num[k]] = n;
                g_num[k]++;
            end
        end else if (m_act[k] && n == m_n0[k] + s) begin
            m_f[k]  = m_x[k] ^ m_y[k];
            m_co[k] = (m_x[k] >> 4) & 1;
            m_ov[k] = m_y[k] & 1;
        end else if (resp && rr[k][m_own[k]]) begin
            m_act[k] = 0;
            m_cnt[k] = (m_cnt[k] + 1) % ((k == 0) ? 256 : 4);
        end
    endtask

    task automatic gen_stim();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (mode == MCont) begin
                    if (!rv[k][r] || acc[k][r]) begin
                        rv[k][r] = 1'b1;
                        rs[k][r] = 2'($urandom);
                        rx[k][r] = 5'($urandom);
                        ry[k][r] = 5'($urandom);
                    end
                    rr[k][r] = 1'b1;
                end else if (mode == MRand) begin
                    if (!rv[k][r] || acc[k][r]) begin
                        rv[k][r] = ($urandom_range(0, 2) != 0);
                        rs[k][r] = 2'($urandom);
                        rx[k][r] = 5'($urandom);
                        ry[k][r] = 5'($urandom);
                    end
                    rr[k][r] = ($urandom_range(0, 3) != 0);
                end else if (acc[k][r]) begin
                    rv[k][r] = 1'b0;
                end
            end
        end
        if (mode == MRand) rst = ($urandom_range(0, 79) == 0);
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_cycle(k);
        @(posedge clk);
        #1;
        n++;
        if (rec_cnt && o_cnt[1] != 8'(prev1)) begin
            prev1 = o_cnt[1];
            if (cs_n < 8) begin
                cs[cs_n] = prev1;
                cs_n++;
            end
        end
        gen_stim();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int wexp [5];
        wexp = '{1, 2, 3, 0, 1};
        nvec = 0; nerr = 0; n = 0; chk_en = 0; mode = MCont; rst = 1'b1;
        rec_cnt = 0; prev1 = 0; cs_n = 0;
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_last[k] = 1; m_cnt[k] = 0; m_n0[k] = 0; g_num[k] = 0;
            m_s[k] = 0; m_x[k] = 0; m_y[k] = 0; m_f[k] = 0; m_co[k] = 0; m_ov[k] = 0;
            for (int r = 0; r < 2; r++) begin
                rv[k][r] = 1'b1; rr[k][r] = 1'b1;
                rs[k][r] = 2'($urandom); rx[k][r] = 5'($urandom); ry[k][r] = 5'($urandom);
            end
            rs[k][0] = 2'b00; rx[k][0] = 5'b01111; ry[k][0] = 5'b00001;
        end

        // Reset held three cycles with both requesters valid
        step();
        chk_en = 1;
        step();
        step();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("k%0d reset busy", k), o_busy[k], 0);
            check_eq($sformatf("k%0d reset op_count", k), o_cnt[k], 0);
            check_eq($sformatf("k%0d reset alu_x", k), o_x[k], 0);
            check_eq($sformatf("k%0d reset rsp_f", k), o_f[k], 0);
            check_eq($sformatf("k%0d first grant A", k), o_rdy[k][0], 1);
            check_eq($sformatf("k%0d first grant not B", k), o_rdy[k][1], 0);
        end

        // Single A operation on the SETTLE=1 instance, then continuous contention
        rec_cnt = 1;
        step();
        #1;
        check_eq("k0 alu_x after E0", o_x[0], 5'b01111);
        check_eq("k0 alu_y after E0", o_y[0], 5'b00001);
        check_eq("k0 alu_s after E0", o_s[0], 0);
        step();
        #1;
        check_eq("k0 a_rsp_valid at E0+1", o_rv[0][0], 1);
        check_eq("k0 b_rsp_valid at E0+1", o_rv[0][1], 0);
        check_eq("k0 rsp_f", o_f[0], 5'b01110);
        check_eq("k0 rsp_cout", o_co[0], 0);
        check_eq("k0 rsp_ovf", o_ov[0], 1);
        step();
        #1;
        check_eq("k0 op_count after handshake", o_cnt[0], 1);
        repeat (24) step();
        rec_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("k%0d six grants", k), g_num[k] >= 6, 1);
            for (int i = 0; i < 6; i++) begin
                check_eq($sformatf("k%0d grant order %0d", k, i), g_own[k][i], i % 2);
                if (i > 0)
                    check_eq($sformatf("k%0d spacing %0d", k, i),
                             g_cyc[k][i] - g_cyc[k][i-1], (k == 0) ? 3 : 5);
            end
        end
        check_eq("k1 wrap samples", cs_n >= 5, 1);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("k1 op_count seq %0d", i), cs[i], wexp[i]);

        // Response backpressure on a B operation while A waits
        mode = MDir;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 2; r++) begin rv[k][r] = 1'b0; rr[k][r] = 1'b1; end
        do_reset(3);
        for (int k = 0; k < 2; k++) begin
            rv[k][1] = 1'b1; rs[k][1] = 2'b01; rx[k][1] = 5'b10100; ry[k][1] = 5'b10110;
            rr[k][1] = 1'b0;
        end
        step();
        for (int k = 0; k < 2; k++) begin
            rv[k][0] = 1'b1;
            rs[k][0] = 2'($urandom); rx[k][0] = 5'($urandom); ry[k][0] = 5'($urandom);
        end
        repeat (7) begin
            for (int k = 0; k < 2; k++) rr[k][0] = n[0];
            step();
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("k%0d bp rsp_f", k), o_f[k], 5'b00010);
            check_eq($sformatf("k%0d bp rsp_cout", k), o_co[k], 1);
            check_eq($sformatf("k%0d bp rsp_ovf", k), o_ov[k], 0);
            check_eq($sformatf("k%0d bp b_rsp_valid", k), o_rv[k][1], 1);
            check_eq($sformatf("k%0d bp no accept", k), o_rdy[k][0], 0);
        end
        step();
        for (int k = 0; k < 2; k++) rr[k][1] = 1'b1;
        step();
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("k%0d bp idle", k), o_busy[k], 0);
            check_eq($sformatf("k%0d bp A granted", k), o_rdy[k][0], 1);
            rr[k][0] = 1'b1;
        end
        repeat (6) step();

        // Reset during ISSUE (instance 1) / RESP (instance 0), then during RESP on both
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 2; r++) begin rv[k][r] = 1'b0; rr[k][r] = 1'b0; end
        do_reset(2);
        for (int k = 0; k < 2; k++) begin
            rv[k][0] = 1'b1; rx[k][0] = 5'($urandom); ry[k][0] = 5'($urandom);
        end
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("k%0d rst issue busy", k), o_busy[k], 0);
            check_eq($sformatf("k%0d rst issue a_rsp_valid", k), o_rv[k][0], 0);
            check_eq($sformatf("k%0d rst issue op_count", k), o_cnt[k], 0);
            rv[k][0] = 1'b1; rv[k][1] = 1'b1;
            rx[k][0] = 5'($urandom); rx[k][1] = 5'($urandom);
        end
        #1;
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("k%0d rst issue last=B", k), o_rdy[k][0], 1);
        step();
        repeat (4) step();
        #1;
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("k%0d in RESP before rst", k), o_rv[k][0], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("k%0d rst resp busy", k), o_busy[k], 0);
            check_eq($sformatf("k%0d rst resp a_rsp_valid", k), o_rv[k][0], 0);
            check_eq($sformatf("k%0d rst resp op_count", k), o_cnt[k], 0);
            rv[k][0] = 1'b1;
        end
        #1;
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("k%0d rst resp last=B", k), o_rdy[k][0], 1);

        // Randomized traffic with random backpressure and occasional reset
        mode = MRand;
        repeat (2500) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
